// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared ULA state encoding and full-adder helper.
package serial_adder_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction
endpackage

// File: rtl/serial_adder_full_adder.sv
// full_adder: combinational one-bit full adder cell shared by the ULA serial blocks.
module full_adder
    import serial_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = maj3(a, b, ci);
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial unsigned adder, LSB first, one full-adder cell and a registered carry.
// Result and carry-out are held from done until the next operation finishes.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, s_q, s_d;
    logic             c_q, c_d;
    logic             fa_s, fa_co;

    full_adder u_fa (
        .a (a_q[0]),
        .b (b_q[0]),
        .ci(carry_q),
        .s (fa_s),
        .co(fa_co)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        s_d     = s_q;
        c_d     = c_q;
        if (start && state_q != ST_RUN) begin
            a_d     = a;
            b_d     = b;
            carry_d = 1'b0;
            cnt_d   = '0;
            state_d = ST_RUN;
        end else if (state_q == ST_RUN) begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            carry_d = fa_co;
            cnt_d   = cnt_q + 1'b1;
            r_d     = {fa_s, r_q[WIDTH-1:1]};
            if (cnt_q == LAST) begin
                state_d = ST_DONE;
                s_d     = r_d;
                c_d     = fa_co;
            end
        end else if (state_q != ST_IDLE) begin
            // DONE, or the unused encoding, falls back to IDLE
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            s_q     <= s_d;
            c_q     <= c_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign s    = s_q;
    assign c    = c_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder at WIDTH 8 and 32 against {c,s} = a + b.
module tb_serial_adder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start8 = 1'b0, start32 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0, s8;
    logic [31:0] a32 = '0, b32 = '0, s32;
    logic        busy8, done8, c8, busy32, done32, c32;

    int errors = 0, checks = 0, ndone8 = 0, ndone32 = 0, cyc = 0;
    logic [8:0]  q8[$];
    logic [32:0] q32[$];
    logic [8:0]  last8 = '0;
    logic [32:0] last32 = '0;
    logic        prev8 = 1'b0, prev32 = 1'b0;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .s(s8), .c(c8)
    );
    serial_adder #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .s(s32), .c(c32)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [32:0] got, input logic [32:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    always @(negedge rst_n) begin
        last8 = '0; last32 = '0; prev8 = 1'b0; prev32 = 1'b0;
    end

    always @(negedge clk) if (rst_n) begin
        chk("busy_done_overlap8", 33'(busy8 & done8), 33'd0);
        if (done8) begin
            ndone8++;
            chk("done_width8", 33'(prev8), 33'd0);
            if (q8.size() == 0) chk("unexpected_done8", 33'd1, 33'd0);
            else chk("sum8", 33'({c8, s8}), 33'(q8.pop_front()));
            last8 = {c8, s8};
        end else chk("hold8", 33'({c8, s8}), 33'(last8));
        prev8 = done8;
    end

    always @(negedge clk) if (rst_n) begin
        chk("busy_done_overlap32", 33'(busy32 & done32), 33'd0);
        if (done32) begin
            ndone32++;
            chk("done_width32", 33'(prev32), 33'd0);
            if (q32.size() == 0) chk("unexpected_done32", 33'd1, 33'd0);
            else chk("sum32", {c32, s32}, q32.pop_front());
            last32 = {c32, s32};
        end else chk("hold32", {c32, s32}, last32);
        prev32 = done32;
    end

    task automatic issue8(input logic [7:0] x, input logic [7:0] y);
        int n = 0;
        while (busy8 && n < 100) begin @(negedge clk); n++; end
        if (busy8) chk("issue8_timeout", 33'd1, 33'd0);
        a8 = x; b8 = y; start8 = 1'b1;
        q8.push_back({1'b0, x} + {1'b0, y});
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic issue32(input logic [31:0] x, input logic [31:0] y);
        int n = 0;
        while (busy32 && n < 100) begin @(negedge clk); n++; end
        if (busy32) chk("issue32_timeout", 33'd1, 33'd0);
        a32 = x; b32 = y; start32 = 1'b1;
        q32.push_back({1'b0, x} + {1'b0, y});
        @(negedge clk);
        start32 = 1'b0;
    endtask

    task automatic wait_done8();
        int n = 0;
        @(negedge clk);
        while (!done8 && n < 100) begin @(negedge clk); n++; end
        if (!done8) chk("done8_timeout", 33'd1, 33'd0);
    endtask

    initial begin
        int lat, bc, d1, n0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 33'(busy8), 33'd0);
        chk("rst_done", 33'(done8), 33'd0);
        chk("rst_sum", 33'({c8, s8}), 33'd0);
        chk("rst_sum32", {c32, s32}, 33'd0);
        rst_n = 1'b1;
        @(negedge clk);
        // latency and busy length
        issue8(8'h35, 8'h4A);
        lat = 0; bc = 0;
        while (!done8 && lat < 50) begin
            if (busy8) bc++;
            @(negedge clk);
            lat++;
        end
        chk("latency", 33'(lat), 33'd8);
        chk("busy_cycles", 33'(bc), 33'd8);
        issue8(8'hFF, 8'h01); wait_done8();
        issue8(8'hFF, 8'hFF); wait_done8();
        issue8(8'h00, 8'h00); wait_done8();
        // start during RUN is dropped
        issue8(8'h10, 8'h20);
        n0 = ndone8;
        repeat (2) @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8();
        repeat (15) @(negedge clk);
        chk("ignored_start_dones", 33'(ndone8 - n0), 33'd1);
        // back-to-back through DONE
        issue8(8'h0F, 8'h01);
        a8 = 8'h01; b8 = 8'h02; start8 = 1'b1;
        q8.push_back(9'h003);
        wait_done8();
        d1 = cyc;
        @(negedge clk);
        start8 = 1'b0;
        chk("b2b_no_idle", 33'(busy8), 33'd1);
        wait_done8();
        chk("b2b_period", 33'(cyc - d1), 33'd9);
        // asynchronous reset mid-RUN
        a8 = 8'h77; b8 = 8'h11; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n0 = ndone8;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 33'(busy8), 33'd0);
        chk("arst_done", 33'(done8), 33'd0);
        chk("arst_sum", 33'({c8, s8}), 33'd0);
        #1 rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("arst_no_done", 33'(ndone8 - n0), 33'd0);
        issue8(8'h80, 8'h80); wait_done8();
        // randomized, both widths concurrently
        fork
            for (int i = 0; i < 1000; i++) issue8(8'($urandom_range(255)), 8'($urandom_range(255)));
            for (int i = 0; i < 1000; i++) issue32($urandom, $urandom);
        join
        begin
            int n = 0;
            while ((q8.size() != 0 || q32.size() != 0) && n < 200) begin @(negedge clk); n++; end
        end
        chk("drain8", 33'(q8.size()), 33'd0);
        chk("drain32", 33'(q32.size()), 33'd0);
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
